// File: rtl/pmem_arbiter_if.sv
// Bundle of the two cache pmem ports and the cacheline-adaptor port around pmem_arbiter.
// The slave modport is the arbiter's view; the master modport is the caches/adaptor side.
interface pmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Shares one cacheline memory port between icache and dcache; grant held until mem_resp.
// Define PMEM_ARB_RR_EN for round-robin tie breaking (default: dcache always wins ties).
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic           clk,
  input  logic           rst,
  pmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_req_i;
  logic              w_req_d;
  logic              w_prio_d;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_done;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [LINE_W-1:0] r_mem_wdata;

  assign w_req_i = bus.i_pmem_read;
  assign w_req_d = bus.d_pmem_read | bus.d_pmem_write;

`ifdef PMEM_ARB_RR_EN
  // 1 = dcache held the most recent grant; reset value means icache, so first tie goes to D
  logic r_last_grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_grant_d <= 1'b1;
    end else if (w_grant_i) begin
      r_last_grant_d <= 1'b0;
    end
  end

  assign w_prio_d = ~r_last_grant_d;
`else
  assign w_prio_d = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_d && (w_prio_d || !w_req_i)) begin
          w_grant_d   = 1'b1;
          w_state_nxt = SERVE_D;
        end else if (w_req_i) begin
          w_grant_i   = 1'b1;
          w_state_nxt = SERVE_I;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_resp) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command is latched only at grant, so requester inputs are ignored while serving
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= {ADDR_W{1'b0}};
      r_mem_wdata   <= {LINE_W{1'b0}};
    end else if (w_grant_d) begin
      r_mem_address <= bus.d_pmem_address;
      r_mem_wdata   <= bus.d_pmem_wdata;
      r_mem_write   <= bus.d_pmem_write;
      r_mem_read    <= ~bus.d_pmem_write;
    end else if (w_grant_i) begin
      r_mem_address <= bus.i_pmem_address;
      r_mem_write   <= 1'b0;
      r_mem_read    <= 1'b1;
    end else if (w_done) begin
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
    end
  end

  assign bus.mem_read     = r_mem_read;
  assign bus.mem_write    = r_mem_write;
  assign bus.mem_address  = r_mem_address;
  assign bus.mem_wdata    = r_mem_wdata;

  // Stale mem_resp in IDLE never reaches a cache
  assign bus.i_pmem_resp  = ~rst & (r_state == SERVE_I) & bus.mem_resp;
  assign bus.d_pmem_resp  = ~rst & (r_state == SERVE_D) & bus.mem_resp;
  assign bus.i_pmem_rdata = bus.mem_rdata;
  assign bus.d_pmem_rdata = bus.mem_rdata;

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares one cacheline-wide physical memory port between the instruction cache and the data cache.
- Sits between the two cache controllers' pmem interfaces and the cacheline adaptor.
- Grants one requester at a time and holds the grant until memory responds.
- Registers the address, write data and command at grant, and routes the response back only to the granted cache.

Parameters:
- ADDR_W, 32, physical address width.
- LINE_W, 256, cacheline width in bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_pmem_read  in  1  icache line-fill request
- i_pmem_address  in  ADDR_W  icache line address
- i_pmem_rdata  out  LINE_W  line data to the icache
- i_pmem_resp  out  1  one-cycle completion pulse to the icache
- d_pmem_read  in  1  dcache line-fill request
- d_pmem_write  in  1  dcache write-back request
- d_pmem_address  in  ADDR_W  dcache line address
- d_pmem_wdata  in  LINE_W  dcache write-back line
- d_pmem_rdata  out  LINE_W  line data to the dcache
- d_pmem_resp  out  1  one-cycle completion pulse to the dcache
- mem_read  out  1  read command to the adaptor (registered)
- mem_write  out  1  write command to the adaptor (registered)
- mem_address  out  ADDR_W  registered address
- mem_wdata  out  LINE_W  registered write line
- mem_rdata  in  LINE_W  line data from the adaptor
- mem_resp  in  1  adaptor completion pulse

Behaviour:
- Reset is asynchronous and active-high: clk plus rst, rst asynchronous, active-high.
- Reset values: state=IDLE; mem_read=0, mem_write=0, mem_address=0, mem_wdata=0; last_grant=I.
- Resp outputs are 0 during reset. The rdata outputs follow mem_rdata combinationally at all times.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one request pending:
  - Next state is the matching SERVE state.
  - On the same edge, mem_address, mem_wdata and the command are loaded from that requester.
  - mem_wdata is loaded from d_pmem_wdata for D grants; it holds its previous value for I grants.
- IDLE, both requests pending: fixed priority, D wins. I is granted once D's request drops.
- Dcache command encoding on grant: d_pmem_write=1 gives mem_write=1, mem_read=0, even if d_pmem_read is also 1 (write wins). d_pmem_read only gives mem_read=1.
- SERVE_x:
  - Hold the registered command, address and wdata stable. Ignore changes on the requester inputs.
  - When mem_resp=1: drive x_pmem_resp=1 combinationally in the same cycle. Drive the other resp 0. Clear mem_read and mem_write on that edge. Next state is IDLE.
- Grant latency: a request seen in IDLE reaches the mem_* outputs 1 cycle later. Minimum latency from request to resp is 2 cycles.
- Mandatory IDLE cycle after every response. The requester changes its state on the resp edge, so the next grant samples the cache's new request. A dcache write-back followed by a fill is two separate grants.
- mem_resp while in IDLE (stale, e.g. after reset mid-transfer): ignored, no resp to either cache.
- rst asserted mid-transaction: immediate return to IDLE with commands deasserted. The adaptor must tolerate the dropped command.
- The arbiter never issues mem_read and mem_write together.

Optional Feature:
- Macro: PMEM_ARB_RR_EN.
- Defined:
  - Round-robin on simultaneous requests: grant the requester not in last_grant.
  - last_grant updates on every grant.
  - last_grant is I after reset, so the first tie goes to D.
- Undefined: fixed D-over-I priority, and the last_grant register is not built.

Test Plan:
- Icache read alone:
  - Stimulus: i_pmem_read=1, address 0x0000_1040; mem_rdata=0xA5..A5 with mem_resp after 4 cycles.
  - Response: mem_read rises 1 cycle after the request; i_pmem_resp pulses for 1 cycle with i_pmem_rdata=0xA5..A5; d_pmem_resp stays 0.
- Dcache write-back then fill:
  - Stimulus: d_pmem_write=1, address 0x0000_2000, wdata=0x1111..; after resp, d_pmem_read=1, address 0x0000_3000.
  - Response: mem_write with 0x2000/0x1111..; one IDLE cycle; then mem_read with 0x3000; two d_pmem_resp pulses.
- Simultaneous requests: i and d both asserted in the same cycle -> D is served first and I afterwards. With PMEM_ARB_RR_EN, a second simultaneous tie goes to I.
- Input change during service: change d_pmem_address from 0x4000 to 0x5000 while in SERVE_D -> mem_address remains 0x4000 until the resp.
- Reset mid-transfer: rst during SERVE_I, then a stray mem_resp -> mem_read=0 immediately; no resp pulse to either cache.
- Illegal dual command: d_pmem_read=1 and d_pmem_write=1 together -> only mem_write is asserted.
